ctrl_pipe: RTL and testbench

- Carries the ID-stage control bundle from the main decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RISC-V core.
- Generates PCSrcE, the taken branch/jump redirect, in EX.
- Supports stall and flush for the hazard unit.
- Supplies the per-stage RegWrite, Rd and ResultSrc values the forwarding and hazard logic use.

---
 rtl/ctrl_pipe.sv | 141 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control-bundle registers plus the EX-stage PCSrcE redirect.
// Latency 1/2/3 cycles to the E/M/W outputs; StallE holds E and sends a bubble into M, FlushE wins over StallE.
// Optional bubble counter is enabled by defining CTRL_PIPE_BUBBLE_CNT_EN; without it BubbleCnt is tied to 0.
module ctrl_pipe #(
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ALUOpD,
    input  logic [RD_W-1:0]  RdD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ZeroE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             ALUSrcE,
    output logic [1:0]       ALUOpE,
    output logic [RD_W-1:0]  RdE,
    output logic             PCSrcE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [RD_W-1:0]  RdM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [RD_W-1:0]  RdW,
    output logic [CNT_W-1:0] BubbleCnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      alu_op;
        logic [RD_W-1:0] rd;
    } ex_t;

    // Later stages keep only the fields anything downstream still consumes.
    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic [RD_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic [RD_W-1:0] rd;
    } wb_t;

    ex_t  d_bus;
    ex_t  e_q;
    mem_t m_q;
    wb_t  w_q;

    // Every field is masked by ValidD so X on an idle decoder cannot reach E.
    always_comb begin
        d_bus = '0;
        if (ValidD) begin
            d_bus = '{valid: 1'b1, reg_write: RegWriteD, result_src: ResultSrcD,
                      mem_write: MemWriteD, jump: JumpD, branch: BranchD,
                      alu_src: ALUSrcD, alu_op: ALUOpD, rd: RdD};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else if (FlushE) begin
            e_q <= '0;
        end else if (!StallE) begin
            e_q <= d_bus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
        end else if (StallE && !FlushE) begin
            m_q <= '0;
        end else begin
            m_q <= '{reg_write: e_q.reg_write, result_src: e_q.result_src,
                     mem_write: e_q.mem_write, rd: e_q.rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else begin
            w_q <= '{reg_write: m_q.reg_write, result_src: m_q.result_src, rd: m_q.rd};
        end
    end

`ifdef CTRL_PIPE_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;

    // A flush, an idle decode or a stall each put exactly one bubble into the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if ((FlushE || StallE || !ValidD) && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign BubbleCnt = bubble_cnt;
`else
    assign BubbleCnt = '0;
`endif

    assign RegWriteE  = e_q.reg_write;
    assign ResultSrcE = e_q.result_src;
    assign ALUSrcE    = e_q.alu_src;
    assign ALUOpE     = e_q.alu_op;
    assign RdE        = e_q.rd;
    assign PCSrcE     = e_q.valid & (e_q.jump | (e_q.branch & ZeroE));

    assign RegWriteM  = m_q.reg_write;
    assign MemWriteM  = m_q.mem_write;
    assign ResultSrcM = m_q.result_src;
    assign RdM        = m_q.rd;

    assign RegWriteW  = w_q.reg_write;
    assign ResultSrcW = w_q.result_src;
    assign RdW        = w_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios then random traffic against a stage-list reference model.
module tb_ctrl_pipe;
    localparam int RD_W  = 5;
    localparam int CNT_W = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ValidD = 1'b0, RegWriteD = 1'b0, MemWriteD = 1'b0, JumpD = 1'b0;
    logic BranchD = 1'b0, ALUSrcD = 1'b0, StallE = 1'b0, FlushE = 1'b0, ZeroE = 1'b0;
    logic [1:0] ResultSrcD = 2'b00, ALUOpD = 2'b00;
    logic [RD_W-1:0] RdD = '0;
    logic RegWriteE, ALUSrcE, PCSrcE, RegWriteM, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcE, ALUOpE, ResultSrcM, ResultSrcW;
    logic [RD_W-1:0] RdE, RdM, RdW;
    logic [CNT_W-1:0] BubbleCnt;

    always #5 clk = ~clk;

    ctrl_pipe #(.RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUOpD(ALUOpD), .RdD(RdD),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
        .ALUOpE(ALUOpE), .RdE(RdE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .BubbleCnt(BubbleCnt)
    );

    typedef struct {
        logic            valid;
        logic            rw;
        logic [1:0]      rs;
        logic            mw;
        logic            j;
        logic            b;
        logic            as;
        logic [1:0]      op;
        logic [RD_W-1:0] rd;
    } bun_t;

    // Reference: a list of instruction bundles, index 0 = EX, 1 = MEM, 2 = WB.
    bun_t stg [3];
    int unsigned cnt_model;
    int errors = 0;
    int checks = 0;

    function automatic bun_t bubble();
        bun_t t;
        t.valid = 1'b0; t.rw = 1'b0; t.rs = 2'b00; t.mw = 1'b0; t.j = 1'b0;
        t.b = 1'b0; t.as = 1'b0; t.op = 2'b00; t.rd = '0;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_cnt;
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
        exp_cnt = cnt_model;
`else
        exp_cnt = 0;
`endif
        chk("RegWriteE", RegWriteE, stg[0].rw);
        chk("ResultSrcE", ResultSrcE, stg[0].rs);
        chk("ALUSrcE", ALUSrcE, stg[0].as);
        chk("ALUOpE", ALUOpE, stg[0].op);
        chk("RdE", RdE, stg[0].rd);
        chk("PCSrcE", PCSrcE, stg[0].valid & (stg[0].j | (stg[0].b & ZeroE)));
        chk("RegWriteM", RegWriteM, stg[1].rw);
        chk("MemWriteM", MemWriteM, stg[1].mw);
        chk("ResultSrcM", ResultSrcM, stg[1].rs);
        chk("RdM", RdM, stg[1].rd);
        chk("RegWriteW", RegWriteW, stg[2].rw);
        chk("ResultSrcW", ResultSrcW, stg[2].rs);
        chk("RdW", RdW, stg[2].rd);
        chk("BubbleCnt", BubbleCnt, exp_cnt);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic j, input logic b, input logic as, input logic [1:0] op,
                         input logic [RD_W-1:0] rd);
        ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j;
        BranchD = b; ALUSrcD = as; ALUOpD = op; RdD = rd;
    endtask

    task automatic drive_x();
        ValidD = 1'b0; RegWriteD = 'x; ResultSrcD = 'x; MemWriteD = 'x; JumpD = 'x;
        BranchD = 'x; ALUSrcD = 'x; ALUOpD = 'x; RdD = 'x;
    endtask

    // Advance one clock: the instruction moves one stage on, a stall duplicates nothing,
    // a flush or idle decode injects an empty slot into EX.
    task automatic step(input bit do_check);
        bun_t d;
        bun_t nxt [3];
        d = bubble();
        if (ValidD === 1'b1) begin
            d.valid = 1'b1; d.rw = RegWriteD; d.rs = ResultSrcD; d.mw = MemWriteD;
            d.j = JumpD; d.b = BranchD; d.as = ALUSrcD; d.op = ALUOpD; d.rd = RdD;
        end
        nxt[2] = stg[1];
        nxt[1] = (StallE && !FlushE) ? bubble() : stg[0];
        if (FlushE)      nxt[0] = bubble();
        else if (StallE) nxt[0] = stg[0];
        else             nxt[0] = d;
        if ((FlushE || StallE || !ValidD) && cnt_model < CNT_MAX) cnt_model++;
        @(posedge clk);
        stg = nxt;
        #1;
        if (do_check) check_all();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        stg[0] = bubble(); stg[1] = bubble(); stg[2] = bubble();
        cnt_model = 0;
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        async_reset();

        // R-type: E at 1 cycle, M at 2, W at 3.
        drive(1, 1, 2'b00, 0, 0, 0, 0, 2'b10, 5);
        step(1);
        chk("rtype_RegWriteE", RegWriteE, 1); chk("rtype_RdE", RdE, 5);
        drive(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        step(1);
        chk("rtype_RegWriteM", RegWriteM, 1);
        step(1);
        chk("rtype_RegWriteW", RegWriteW, 1); chk("rtype_RdW", RdW, 5);

        // Store: MemWriteM for exactly one cycle, no register write.
        drive(1, 0, 2'b00, 1, 0, 0, 1, 2'b00, 0);
        step(1);
        drive(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        step(1);
        chk("store_MemWriteM", MemWriteM, 1);
        step(1);
        chk("store_MemWriteM_off", MemWriteM, 0); chk("store_RegWriteW", RegWriteW, 0);

        // Branch taken / not taken, jump, then flush of the redirecting instruction.
        drive(1, 0, 2'b00, 0, 0, 1, 0, 2'b01, 0);
        ZeroE = 1'b1;
        step(1);
        chk("branch_taken", PCSrcE, 1);
        ZeroE = 1'b0;
        #1;
        chk("branch_not_taken", PCSrcE, 0);
        drive(1, 1, 2'b10, 0, 1, 0, 0, 2'b00, 1);
        step(1);
        chk("jump_taken", PCSrcE, 1);
        FlushE = 1'b1;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        step(1);
        chk("flush_PCSrcE", PCSrcE, 0); chk("flush_RegWriteE", RegWriteE, 0);
        step(1);
        chk("flush_twice_RdE", RdE, 0);
        FlushE = 1'b0;

        // Load-use: load held one cycle in E, M sees a bubble, load retires once.
        drive(1, 1, 2'b01, 0, 0, 0, 1, 2'b00, 7);
        step(1);
        chk("load_RdE", RdE, 7);
        StallE = 1'b1;
        drive(1, 1, 2'b00, 0, 0, 0, 0, 2'b10, 9);
        step(1);
        chk("stall_RdE_held", RdE, 7); chk("stall_RegWriteM", RegWriteM, 0);
        StallE = 1'b0;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        step(1);
        chk("load_RdM", RdM, 7); chk("load_RegWriteM", RegWriteM, 1);
        step(1);
        chk("load_RdW", RdW, 7); chk("load_ResultSrcW", ResultSrcW, 2'b01);
        step(1);
        chk("load_once_RegWriteW", RegWriteW, 0);

        // Flush beats stall; idle decode with X inputs gives a clean bubble.
        drive(1, 1, 2'b10, 1, 1, 1, 1, 2'b11, 31);
        FlushE = 1'b1; StallE = 1'b1;
        step(1);
        chk("flush_stall_RegWriteE", RegWriteE, 0); chk("flush_stall_RdE", RdE, 0);
        FlushE = 1'b0; StallE = 1'b0;
        drive_x();
        step(1);
        chk("x_mask_RdE", RdE, 0); chk("x_mask_ALUOpE", ALUOpE, 0);

        // Async reset with all stages full.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'(i), 0, 0, 0, 1, 2'b10, RD_W'(i + 3));
            step(1);
        end
        async_reset();
        chk("rst_RegWriteW", RegWriteW, 0);

        // Three flushes plus two idle decodes.
        FlushE = 1'b1;
        drive(1, 1, 2'b00, 0, 0, 0, 0, 2'b10, 4);
        for (int i = 0; i < 3; i++) step(1);
        FlushE = 1'b0;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 2; i++) step(1);
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
        chk("bubble_cnt_5", BubbleCnt, 5);
`else
        chk("bubble_cnt_off", BubbleCnt, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) drive_x();
                else drive(0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom), 2'($urandom), RD_W'($urandom));
            end else begin
                drive(1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 2'($urandom), RD_W'($urandom));
            end
            StallE = ($urandom_range(4) == 0);
            FlushE = ($urandom_range(5) == 0);
            ZeroE  = 1'($urandom);
            step(1);
        end
        StallE = 1'b0; FlushE = 1'b0;

`ifdef CTRL_PIPE_BUBBLE_CNT_EN
        // Saturation: more bubbles than the counter can represent.
        FlushE = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 2; i++) step(0);
        check_all();
        chk("bubble_cnt_sat", BubbleCnt, CNT_MAX);
        FlushE = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
